// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared state encoding and default tick divider for the stopwatch controller
package stopwatch_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    LAP   = 2'd3
  } sw_state_t;
  localparam int TICK_DIV_DEFAULT = 500000;
endpackage

// File: rtl/btn_edge_sync.sv
// btn_edge_sync: button synchronizer plus registered rising-edge detector, one press per hold
module btn_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press
);
  logic [SYNC_STAGES-1:0] sync;
  logic [SYNC_STAGES-1:0] vld;
  logic prev;
  logic armed;
  // armed only after a genuine low sample, so a button held through reset stays silent
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sync  <= '0;
      vld   <= '0;
      prev  <= 1'b0;
      armed <= 1'b0;
      press <= 1'b0;
    end else begin
      sync  <= {sync[SYNC_STAGES-2:0], btn};
      vld   <= {vld[SYNC_STAGES-2:0], 1'b1};
      prev  <= sync[SYNC_STAGES-1];
      armed <= armed | (vld[SYNC_STAGES-1] & ~sync[SYNC_STAGES-1]);
      press <= sync[SYNC_STAGES-1] & ~prev & armed;
    end
endmodule

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: two-button stopwatch FSM with tick prescaler, saturation stop and lap hold
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int TICK_DIV    = TICK_DIV_DEFAULT,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_start_stop,
  input  logic       btn_lap_reset,
  input  logic       max_reached,
  output logic       tick_en,
  output logic       cnt_clr,
  output logic       disp_hold,
  output logic       running,
  output logic [1:0] state
);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);
  sw_state_t cur, nxt;
  logic [PW-1:0] presc, presc_nxt;
  logic ss, lr, active, wrap, tick_nxt, clr_nxt;
  btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_ss (
    .clk(clk), .reset(reset), .btn(btn_start_stop), .press(ss)
  );
  btn_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_lr (
    .clk(clk), .reset(reset), .btn(btn_lap_reset), .press(lr)
  );
  // saturation outranks buttons; start/stop outranks lap/reset
  always_comb begin
    active    = cur == RUN || cur == LAP;
    wrap      = active && presc == LAST;
    tick_nxt  = wrap && !max_reached;
    presc_nxt = active ? (wrap ? '0 : presc + PW'(1)) : (cur == IDLE ? '0 : presc);
    nxt       = cur;
    clr_nxt   = 1'b0;
    if (wrap && max_reached) nxt = PAUSE;
    else if (ss) nxt = active ? PAUSE : RUN;
    else if (lr) begin
      nxt     = cur == RUN ? LAP : cur == LAP ? RUN : IDLE;
      clr_nxt = cur == IDLE || cur == PAUSE;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      cur     <= IDLE;
      presc   <= '0;
      tick_en <= 1'b0;
      cnt_clr <= 1'b0;
    end else begin
      cur     <= nxt;
      presc   <= presc_nxt;
      tick_en <= tick_nxt;
      cnt_clr <= clr_nxt;
    end
  assign state     = cur;
  assign disp_hold = cur == LAP;
  assign running   = active;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: directed and random stimulus against a cycle-level behavioural stopwatch model
module tb_stopwatch_ctrl;
  localparam int TD = 4;
  localparam int SS = 2;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic b_ss = 1'b0;
  logic b_lr = 1'b0;
  logic max_r = 1'b0;
  logic tick_en, cnt_clr, disp_hold, running;
  logic [1:0] state;
  int n_chk = 0;
  int n_fail = 0;
  int n_tick = 0;
  int n_clr = 0;
  int m_st, m_cnt, t0, c0;
  bit m_tick, m_clr, p_ss, p_lr;
  bit d_ss[SS+1];
  bit d_lr[SS+1];

  always #5 clk = ~clk;

  stopwatch_ctrl #(.TICK_DIV(TD), .SYNC_STAGES(SS)) dut (
    .clk(clk), .reset(reset), .btn_start_stop(b_ss), .btn_lap_reset(b_lr),
    .max_reached(max_r), .tick_en(tick_en), .cnt_clr(cnt_clr),
    .disp_hold(disp_hold), .running(running), .state(state)
  );

  task automatic check(input string tag, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("state", state, m_st);
    check("tick_en", tick_en, m_tick);
    check("cnt_clr", cnt_clr, m_clr);
    check("disp_hold", disp_hold, m_st == 3);
    check("running", running, m_st == 1 || m_st == 3);
  endtask

  // states: 0 idle, 1 run, 2 pause, 3 lap; events act SS+1 edges after the edge that first samples the press
  task automatic model_reset();
    m_st = 0;
    m_cnt = 0;
    m_tick = 0;
    m_clr = 0;
    p_ss = b_ss;
    p_lr = b_lr;
    for (int i = 0; i <= SS; i++) begin
      d_ss[i] = 0;
      d_lr[i] = 0;
    end
  endtask

  task automatic model_edge();
    bit e_ss, e_lr, act, wrap;
    if (reset) begin
      model_reset();
      return;
    end
    e_ss = d_ss[SS];
    e_lr = d_lr[SS] && !d_ss[SS];
    for (int i = SS; i > 0; i--) begin
      d_ss[i] = d_ss[i-1];
      d_lr[i] = d_lr[i-1];
    end
    d_ss[0] = b_ss && !p_ss;
    d_lr[0] = b_lr && !p_lr;
    p_ss = b_ss;
    p_lr = b_lr;
    act = m_st == 1 || m_st == 3;
    wrap = act && m_cnt == TD - 1;
    m_tick = wrap && !max_r;
    m_clr = 0;
    m_cnt = act ? (m_cnt + 1) % TD : (m_st == 0 ? 0 : m_cnt);
    if (wrap && max_r) m_st = 2;
    else if (e_ss) m_st = act ? 2 : 1;
    else if (e_lr) begin
      m_clr = m_st == 0 || m_st == 2;
      m_st = m_st == 1 ? 3 : (m_st == 3 ? 1 : 0);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
      n_tick += int'(tick_en);
      n_clr += int'(cnt_clr);
    end
  endtask

  task automatic press(input bit s, input bit l, input int hold);
    b_ss = s;
    b_lr = l;
    step(hold);
    b_ss = 0;
    b_lr = 0;
  endtask

  task automatic do_reset();
    #2 reset = 1;
    #1;
    model_reset();
    compare_all();
    step(2);
    reset = 0;
    step(4);
  endtask

  initial begin
    #1 reset = 1;
    #1;
    model_reset();
    compare_all();
    step(2);
    reset = 0;
    step(4);
    b_ss = 1;
    step(3);
    check("pre_run", state, 0);
    step(1);
    check("run_latency", state, 1);
    b_ss = 0;
    step(3);
    check("no_early_tick", tick_en, 0);
    step(1);
    check("first_tick", tick_en, 1);
    t0 = n_tick;
    step(12);
    check("tick_period", n_tick - t0, 3);
    press(0, 1, 2); step(4);
    check("lap_hold", disp_hold, 1);
    t0 = n_tick;
    step(8);
    check("lap_ticks", n_tick - t0, 2);
    press(0, 1, 2); step(4);
    check("lap_release", disp_hold, 0);
    press(1, 0, 2); step(4);
    t0 = n_tick;
    step(10);
    check("pause_no_ticks", n_tick - t0, 0);
    press(1, 0, 2); step(4);
    check("resume", state, 1);
    press(1, 0, 2); step(4);
    c0 = n_clr;
    press(0, 1, 2); step(4);
    check("clr_once", n_clr - c0, 1);
    check("to_idle", state, 0);
    press(1, 0, 2); step(4);
    press(1, 1, 2); step(4);
    check("ss_priority", state, 2);
    press(1, 0, 2); step(4);
    max_r = 1;
    t0 = n_tick;
    step(TD + 1);
    check("sat_pause", state, 2);
    check("sat_no_tick", n_tick - t0, 0);
    max_r = 0;
    b_ss = 1;
    step(20);
    b_ss = 0;
    step(3);
    check("held_one_event", state, 1);
    press(0, 1, 2); step(4);
    check("in_lap", state, 3);
    do_reset();
    b_ss = 1;
    step(3);
    do_reset();
    step(10);
    check("held_thru_reset", state, 0);
    b_ss = 0;
    step(3);
    press(1, 0, 2); step(4);
    check("rearmed", state, 1);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) b_ss = ~b_ss;
      if ($urandom_range(0, 7) == 0) b_lr = ~b_lr;
      max_r = $urandom_range(0, 15) == 0;
      step(1);
      if (i % 700 == 699) do_reset();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
